dmgplus_cart_rd: RTL and testbench

- Cartridge-bus read engine; sits directly upstream of the splash generator.
- Turns a single-cycle `rom_rd` request with `rom_addr` into a timed Game Boy cart bus read cycle on `cart_a` / `cart_rd_n` / `cart_cs_n`.
- Latches the byte into `rom_data` and drives `rom_bsy` so the consumer waits correctly.
- Releases the cart bus to the console when not owner.

---
 rtl/dmgplus_cart_rd.sv | 178 +++++++++++++++++
 tb/tb_dmgplus_cart_rd.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmgplus_cart_rd.sv
// Game Boy cartridge-bus read engine: turns a one-cycle rom_rd into a timed /RD cycle and latches the byte.
// Optional `DMGPLUS_CART_DBLREAD_EN re-reads until two consecutive samples agree (or MAX_READS is reached).
module dmgplus_cart_rd #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter int unsigned MAX_READS     = 8
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic        bus_own,
  input  logic [15:0] rom_addr,
  input  logic        rom_rd,
  output logic [7:0]  rom_data,
  output logic        rom_bsy,
  output logic        rom_err,
  output logic [15:0] cart_a,
  input  logic [7:0]  cart_d,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n,
  output logic        cart_oe
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES must be 1..15");
  end
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
    $error("ACCESS_CYCLES must be 1..15");
  end
  if (MAX_READS < 2 || MAX_READS > 15) begin : g_bad_reads
    $error("MAX_READS must be 2..15");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_n_q, rd_n_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_q;
  logic [7:0]  data_q, data_d;
  logic        accept;

`ifdef DMGPLUS_CART_DBLREAD_EN
  localparam logic [3:0] LAST_READ = 4'(MAX_READS - 1);
  logic [3:0] nreads_q, nreads_d;
  logic       err_q, err_d;
  logic       match;

  // data_q still holds the previous sample of this request, so it doubles as the compare reference.
  assign match = (nreads_q != 4'd0) && (cart_d == data_q);
`endif

  assign accept = rom_rd & bus_own & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    rd_n_d  = rd_n_q;
    cs_n_d  = cs_n_q;
    data_d  = data_q;
`ifdef DMGPLUS_CART_DBLREAD_EN
    nreads_d = nreads_q;
    err_d    = err_q;
`endif
    if (!bus_own) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      rd_n_d  = 1'b1;
      cs_n_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rom_rd) begin
            addr_d  = rom_addr;
            busy_d  = 1'b1;
            cnt_d   = SETUP_LD;
            state_d = S_SETUP;
`ifdef DMGPLUS_CART_DBLREAD_EN
            nreads_d = 4'd0;
`endif
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) begin
            cnt_d   = ACCESS_LD;
            state_d = S_STROBE;
            rd_n_d  = 1'b0;
            cs_n_d  = (addr_q[15:13] != 3'b101);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_STROBE: begin
          if (cnt_q == 4'd0) begin
            data_d  = cart_d;
            rd_n_d  = 1'b1;
            cs_n_d  = 1'b1;
            state_d = S_HOLD;
`ifdef DMGPLUS_CART_DBLREAD_EN
            nreads_d = nreads_q + 4'd1;
            if (!match) begin
              if (nreads_q == LAST_READ) begin
                err_d = 1'b1;
              end else begin
                state_d = S_SETUP;
                cnt_d   = SETUP_LD;
              end
            end
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      rd_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      rd_n_q  <= rd_n_d;
      cs_n_q  <= cs_n_d;
      oe_q    <= bus_own;
      data_q  <= data_d;
    end
  end

`ifdef DMGPLUS_CART_DBLREAD_EN
  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      nreads_q <= '0;
      err_q    <= 1'b0;
    end else begin
      nreads_q <= nreads_d;
      err_q    <= err_d;
    end
  end
  assign rom_err = err_q;
`else
  assign rom_err = 1'b0;
`endif

  assign rom_bsy   = busy_q | accept;
  assign rom_data  = data_q;
  assign cart_a    = addr_q;
  assign cart_rd_n = rd_n_q;
  assign cart_cs_n = cs_n_q;
  assign cart_wr_n = 1'b1;
  assign cart_oe   = oe_q;

endmodule

// File: tb/tb_dmgplus_cart_rd.sv
// Self-checking bench for dmgplus_cart_rd: scoreboard of expected bytes, plus cycle-level bus timing checks.
module tb_dmgplus_cart_rd;

`ifdef DMGPLUS_CART_DBLREAD_EN
  localparam int READS = 2;
`else
  localparam int READS = 1;
`endif
  localparam int BSY_LEN = 2 + READS * 4;
  localparam int STROBES = READS * 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_own;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data;
  logic        rom_bsy;
  logic        rom_err;
  logic [15:0] cart_a;
  logic [7:0]  cart_d;
  logic        cart_rd_n;
  logic        cart_wr_n;
  logic        cart_cs_n;
  logic        cart_oe;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb[$];
  bit          toggle_en = 1'b0;

  dmgplus_cart_rd #(
    .SETUP_CYCLES(1),
    .ACCESS_CYCLES(3),
    .MAX_READS(8)
  ) dut (
    .clk_8m(clk),
    .rst_n(rst_n),
    .bus_own(bus_own),
    .rom_addr(rom_addr),
    .rom_rd(rom_rd),
    .rom_data(rom_data),
    .rom_bsy(rom_bsy),
    .rom_err(rom_err),
    .cart_a(cart_a),
    .cart_d(cart_d),
    .cart_rd_n(cart_rd_n),
    .cart_wr_n(cart_wr_n),
    .cart_cs_n(cart_cs_n),
    .cart_oe(cart_oe)
  );

  always #5 clk = ~clk;

  // Cart model for the retry case: data flips after every strobe.
  always @(posedge cart_rd_n) begin
    if (toggle_en) cart_d = (cart_d == 8'h11) ? 8'h22 : 8'h11;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, rom_data, 8'h00);
    check({tag, "_bsy"}, rom_bsy, 1'b0);
    check({tag, "_err"}, rom_err, 1'b0);
    check({tag, "_a"}, cart_a, 16'h0000);
    check({tag, "_rd_n"}, cart_rd_n, 1'b1);
    check({tag, "_wr_n"}, cart_wr_n, 1'b1);
    check({tag, "_cs_n"}, cart_cs_n, 1'b1);
    check({tag, "_oe"}, cart_oe, 1'b0);
  endtask

  // Issues a request in the current cycle and follows it until rom_bsy drops.
  task automatic run_read(input string tag, input logic [15:0] addr, input logic [7:0] d,
                          input logic [7:0] exp_byte, input bit exp_cs, input int exp_len,
                          input int exp_strobes, input bit dup);
    int idx, rd_first, rd_cnt, cs_cnt, cs_sync_err, a_err;
    logic [7:0] exp;
    cart_d   = d;
    rom_addr = addr;
    rom_rd   = 1'b1;
    #1;
    check({tag, "_bsy_req"}, rom_bsy, 1'b1);
    sb.push_back(exp_byte);
    idx = 1; rd_first = -1; rd_cnt = 0; cs_cnt = 0; cs_sync_err = 0; a_err = 0;
    tick();
    rom_rd = 1'b0;
    for (int k = 0; k < 100 && rom_bsy; k++) begin
      if (!cart_rd_n) begin
        if (rd_first < 0) rd_first = idx;
        rd_cnt++;
      end
      if (!cart_cs_n) cs_cnt++;
      if (exp_cs && (cart_cs_n != cart_rd_n)) cs_sync_err++;
      if (cart_a != addr) a_err++;
      if (dup && idx == 2) begin
        rom_rd   = 1'b1;
        rom_addr = 16'h1234;
      end else begin
        rom_rd = 1'b0;
      end
      idx++;
      tick();
    end
    rom_rd = 1'b0;
    check({tag, "_bsy_len"}, idx, exp_len);
    check({tag, "_rd_start"}, rd_first, 2);
    check({tag, "_rd_cycles"}, rd_cnt, exp_strobes);
    check({tag, "_cs_cycles"}, cs_cnt, exp_cs ? exp_strobes : 0);
    check({tag, "_cs_sync"}, cs_sync_err, 0);
    check({tag, "_addr_hold"}, a_err, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_data"}, rom_data, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus_own = 1'b0; rom_rd = 1'b0; rom_addr = '0; cart_d = '0;
    repeat (3) tick();
    check_reset_values("por");
    rst_n = 1'b1; bus_own = 1'b1;
    tick();
    check("oe_follow", cart_oe, 1'b1);

    run_read("rom0100", 16'h0100, 8'h44, 8'h44, 1'b0, BSY_LEN, STROBES, 1'b0);
    run_read("ramA123", 16'hA123, 8'h9C, 8'h9C, 1'b1, BSY_LEN, STROBES, 1'b0);
    run_read("b2b4000", 16'h4000, 8'h5A, 8'h5A, 1'b0, BSY_LEN, STROBES, 1'b0);
    run_read("dup2222", 16'h2222, 8'h77, 8'h77, 1'b0, BSY_LEN, STROBES, 1'b1);
    run_read("ramBFFF", 16'hBFFF, 8'hC3, 8'hC3, 1'b1, BSY_LEN, STROBES, 1'b0);
    run_read("romC000", 16'hC000, 8'h81, 8'h81, 1'b0, BSY_LEN, STROBES, 1'b0);
    check("err_steady", rom_err, 1'b0);

    // Console takes the bus back in the middle of a strobe.
    cart_d = 8'hEE; rom_addr = 16'h0200; rom_rd = 1'b1;
    tick();
    rom_rd = 1'b0;
    tick();
    check("drop_in_strobe", cart_rd_n, 1'b0);
    bus_own = 1'b0;
    tick();
    check("drop_rd_n", cart_rd_n, 1'b1);
    check("drop_bsy", rom_bsy, 1'b0);
    check("drop_oe", cart_oe, 1'b0);
    rom_addr = 16'h0300; rom_rd = 1'b1;
    #1;
    check("drop_req_bsy", rom_bsy, 1'b0);
    tick();
    rom_rd = 1'b0;
    repeat (3) tick();
    check("drop_idle_rd_n", cart_rd_n, 1'b1);
    check("drop_idle_bsy", rom_bsy, 1'b0);
    check("drop_data_kept", rom_data, 8'h81);
    bus_own = 1'b1;
    tick();

    // Reset while the address is being set up.
    cart_d = 8'h66; rom_addr = 16'hA000; rom_rd = 1'b1;
    tick();
    rom_rd = 1'b0;
    check("rst_setup_a", cart_a, 16'hA000);
    rst_n = 1'b0;
    tick();
    check_reset_values("rst_mid");
    rst_n = 1'b1;
    tick();
    run_read("post_rst", 16'hB00F, 8'h3C, 8'h3C, 1'b1, BSY_LEN, STROBES, 1'b0);

`ifdef DMGPLUS_CART_DBLREAD_EN
    toggle_en = 1'b1;
    run_read("toggle", 16'h0150, 8'h11, 8'h22, 1'b0, 2 + 8 * 4, 8 * 3, 1'b0);
    toggle_en = 1'b0;
    check("toggle_err", rom_err, 1'b1);
    run_read("sticky", 16'h0151, 8'h4D, 8'h4D, 1'b0, 10, 6, 1'b0);
    check("err_sticky", rom_err, 1'b1);
`endif

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
